// File: rtl/fifo_pipe.sv
// rtl/fifo_pipe.sv - shift-register FIFO with per-stage hold/load/shift/clear select
//
// Purpose:
//   DEPTH register stages, each holding a data word and a full flag.
//   Stage 0 is the head and drives data_out_o directly. A word written
//   into an empty FIFO appears at the head one edge later.
//   Occupancy is always compact: full_q[i] is set for every i < count.
//
// Ports:
//   clk_i        clock; all state changes on the rising edge
//   rst_i        synchronous active-high reset
//   shift_in_i   write request; data_in_i is captured on this edge if accepted
//   data_in_i    write data
//   shift_out_i  read request; the head word is consumed on this edge if accepted
//   data_out_o   head word (stage 0 register)
//   empty_o      stage 0 not occupied
//   full_o       last stage occupied
//   count_o      number of occupied stages
//   overflow_o   sticky: a write was rejected because the FIFO was full
//   underflow_o  sticky: a read was rejected because the FIFO was empty

module fifo_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         shift_in_i,
    input  logic [WIDTH-1:0]             data_in_i,
    input  logic                         shift_out_i,
    output logic [WIDTH-1:0]             data_out_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         overflow_o,
    output logic                         underflow_o
);

    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        SEL_HOLD  = 2'b00,
        SEL_LOAD  = 2'b01,
        SEL_SHIFT = 2'b10,
        SEL_CLEAR = 2'b11
    } sel_e;

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] full_q;
    logic [DEPTH-1:0] full_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             overflow_q;
    logic             overflow_d;
    logic             underflow_q;
    logic             underflow_d;

    logic             wr;
    logic             rd;
    sel_e             sel [DEPTH];

    // Flags padded at both ends so every stage sees a previous and a next
    // neighbour: below stage 0 counts as full, above the last stage as empty.
    logic [DEPTH+1:0] flag_ext;
    // Data padded with a zero word above the last stage; shifting it in is
    // never selected, it only keeps the index in range.
    logic [WIDTH-1:0] data_ext [DEPTH+1];

    always_comb begin
        // A write into a full FIFO is accepted only when the head leaves in
        // the same cycle; a read is accepted whenever the head is occupied.
        wr       = shift_in_i & (~full_q[DEPTH-1] | shift_out_i);
        rd       = shift_out_i & full_q[0];
        flag_ext = {1'b0, full_q, 1'b1};

        for (int i = 0; i < DEPTH; i++) begin
            sel[i] = SEL_HOLD;
            unique case ({wr, rd})
                2'b01: begin
                    if (flag_ext[i+2])      sel[i] = SEL_SHIFT;
                    else if (flag_ext[i+1]) sel[i] = SEL_CLEAR;
                end
                2'b10: begin
                    if (~flag_ext[i+1] & flag_ext[i]) sel[i] = SEL_LOAD;
                end
                2'b11: begin
                    // Everything moves down; the last occupied stage takes
                    // the new word so occupancy is unchanged.
                    if (flag_ext[i+2])      sel[i] = SEL_SHIFT;
                    else if (flag_ext[i+1]) sel[i] = SEL_LOAD;
                end
                default: sel[i] = SEL_HOLD;
            endcase
        end

        for (int i = 0; i < DEPTH; i++) begin
            data_ext[i] = data_q[i];
        end
        data_ext[DEPTH] = '0;

        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
            full_d[i] = full_q[i];
            unique case (sel[i])
                SEL_LOAD: begin
                    data_d[i] = data_in_i;
                    full_d[i] = 1'b1;
                end
                SEL_SHIFT: begin
                    data_d[i] = data_ext[i+1];
                    full_d[i] = 1'b1;
                end
                SEL_CLEAR: begin
                    data_d[i] = '0;
                    full_d[i] = 1'b0;
                end
                default: ;
            endcase
        end

        count_d = count_q;
        if (wr & ~rd)      count_d = count_q + CW'(1);
        else if (rd & ~wr) count_d = count_q - CW'(1);

        overflow_d  = overflow_q | (shift_in_i & full_q[DEPTH-1] & ~shift_out_i);
        underflow_d = underflow_q | (shift_out_i & ~full_q[0]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            full_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
            full_q      <= full_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign data_out_o  = data_q[0];
    assign empty_o     = ~full_q[0];
    assign full_o      = full_q[DEPTH-1];
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule

// File: tb/tb_fifo_pipe.sv
// tb/tb_fifo_pipe.sv - self-checking bench for fifo_pipe with a queue scoreboard

module tb_fifo_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             shift_in = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             shift_out = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] sb [$];
    logic             exp_ovf = 1'b0;
    logic             exp_unf = 1'b0;

    fifo_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .shift_in_i  (shift_in),
        .data_in_i   (data_in),
        .shift_out_i (shift_out),
        .data_out_o  (data_out),
        .empty_o     (empty),
        .full_o      (full),
        .count_o     (count),
        .overflow_o  (overflow),
        .underflow_o (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [WIDTH-1:0] head;
        head = (sb.size() > 0) ? sb[0] : '0;
        check({tag, ".data_out"},  32'(data_out),  32'(head));
        check({tag, ".count"},     32'(count),     32'(sb.size()));
        check({tag, ".empty"},     32'(empty),     32'(sb.size() == 0));
        check({tag, ".full"},      32'(full),      32'(sb.size() == DEPTH));
        check({tag, ".overflow"},  32'(overflow),  32'(exp_ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(exp_unf));
    endtask

    // One clock edge with the given requests; the scoreboard is updated from
    // its own pre-edge occupancy, then every output is compared just after.
    task automatic step(input string tag, input logic si, input logic [WIDTH-1:0] di, input logic so);
        bit was_full;
        bit was_empty;
        shift_in  = si;
        data_in   = di;
        shift_out = so;
        @(posedge clk);
        was_full  = (sb.size() == DEPTH);
        was_empty = (sb.size() == 0);
        if (si && was_full && !so) exp_ovf = 1'b1;
        if (so && was_empty)       exp_unf = 1'b1;
        if (so && !was_empty) void'(sb.pop_front());
        if (si && (!was_full || so)) sb.push_back(di);
        #1;
        shift_in  = 1'b0;
        shift_out = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag, input logic si, input logic so);
        rst       = 1'b1;
        shift_in  = si;
        data_in   = 8'hEE;
        shift_out = so;
        @(posedge clk);
        sb.delete();
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        #1;
        rst       = 1'b0;
        shift_in  = 1'b0;
        shift_out = 1'b0;
        check_all(tag);
    endtask

    initial begin
        do_reset("reset", 1'b0, 1'b0);
        step("idle", 1'b0, 8'h00, 1'b0);

        step("push11", 1'b1, 8'h11, 1'b0);
        step("push22", 1'b1, 8'h22, 1'b0);
        step("push33", 1'b1, 8'h33, 1'b0);
        step("push44", 1'b1, 8'h44, 1'b0);
        step("push_ovf", 1'b1, 8'h55, 1'b0);

        step("pop1", 1'b0, 8'h00, 1'b1);
        step("pop2", 1'b0, 8'h00, 1'b1);
        step("pop3", 1'b0, 8'h00, 1'b1);
        step("pop4", 1'b0, 8'h00, 1'b1);
        step("pop_unf", 1'b0, 8'h00, 1'b1);

        do_reset("reset2", 1'b0, 1'b1);
        step("pushA1", 1'b1, 8'hA1, 1'b0);
        step("pushA2", 1'b1, 8'hA2, 1'b0);
        step("bothA3", 1'b1, 8'hA3, 1'b1);
        step("popA2", 1'b0, 8'h00, 1'b1);
        step("popA3", 1'b0, 8'h00, 1'b1);

        do_reset("reset3", 1'b0, 1'b0);
        step("both_empty", 1'b1, 8'h5C, 1'b1);
        step("fill1", 1'b1, 8'h61, 1'b0);
        step("fill2", 1'b1, 8'h62, 1'b0);
        step("fill3", 1'b1, 8'h63, 1'b0);
        step("both_full", 1'b1, 8'h99, 1'b1);
        step("both_full2", 1'b1, 8'h9A, 1'b1);
        for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 8'h00, 1'b1);

        step("pre_rst1", 1'b1, 8'h01, 1'b0);
        step("pre_rst2", 1'b1, 8'h02, 1'b0);
        step("pre_rst3", 1'b1, 8'h03, 1'b0);
        do_reset("reset_mid", 1'b1, 1'b0);
        step("push77", 1'b1, 8'h77, 1'b0);

        for (int i = 0; i < 200; i++) begin
            step("rand", 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        // Sustained simultaneous traffic at each occupancy: one word per cycle.
        for (int c = 1; c <= DEPTH; c++) begin
            do_reset("reset_tp", 1'b0, 1'b0);
            for (int k = 0; k < c; k++) step("tp_fill", 1'b1, 8'(8'h30 + k), 1'b0);
            for (int k = 0; k < 8; k++) step("tp_both", 1'b1, 8'(8'hC0 + k), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_pipe.md
# fifo_pipe

Shift-register FIFO datapath that holds the stages controlled by the per-stage select logic. DEPTH register stages each carry a data word and a full flag; every stage picks its next value from hold, data_in or the stage behind it. Stage 0 is the head and drives data_out directly, so a word written into an empty FIFO falls through to the output in one cycle. The block sits between the producer (shift_in/data_in) and the consumer (shift_out/data_out) of the FIFO pipeline.

## Interface
- WIDTH, 8, data word width
- DEPTH, 4, number of stages (≥2)
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- shift_in  input  1  write request; data_in captured this edge if accepted
- data_in  input  WIDTH  write data
- shift_out  input  1  read request; head word consumed this edge if accepted
- data_out  output  WIDTH  head word (stage 0 register)
- empty  output  1  ~full[0]
- full  output  1  full[DEPTH-1]
- count  output  $clog2(DEPTH+1)  occupied stages
- overflow  output  1  sticky: shift_in rejected while full
- underflow  output  1  sticky: shift_out rejected while empty

## Operation
- Stage i state: data[i] (WIDTH), full[i]. Occupancy is always compact: full[i]=1 exactly for i<count.
- Neighbour flags per stage: prev_full = full[i-1] (stage 0: 1), next_full = full[i+1] (stage DEPTH-1: 0), now_full = full[i].
- Effective requests: wr = shift_in & (~full | shift_out); rd = shift_out & ~empty.
- Per-stage select sel[i], 2 bits: 00 hold, 01 load data_in, 10 load data[i+1], 11 clear.
- rd & ~wr: next_full → 10 (full stays 1); else now_full → 11 (full←0, data←0); else 00.
- wr & ~rd: ~now_full & prev_full → 01 (full←1); else 00.
- wr & rd: next_full → 10; else now_full → 01 (last occupied stage takes new word); else 00.
- Neither: all stages 00.
- Simultaneous on empty: shift_out rejected (underflow set), shift_in accepted into stage 0.
- Simultaneous on full: both accepted; count unchanged; new word lands in stage DEPTH-1.
- count: +1 on wr&~rd, −1 on rd&~wr, else unchanged; never exceeds DEPTH or wraps below 0.
- overflow set when shift_in & full & ~shift_out; underflow set when shift_out & empty. Both stay set until rst.
- Rejected requests never alter data[] or full[].

## Timing
- Reset (rst high at edge): all data[i]=0, full[i]=0; data_out=0, empty=1, full=0, count=0, overflow=0, underflow=0. Reset overrides any simultaneous shift_in/shift_out.
- Reset mid-operation discards contents in one edge; next cycle behaves as fresh empty FIFO.
- All outputs are registered or pure decode of registers; no combinational path from shift_in/shift_out/data_in to any output.
- Write-to-read latency: word written at edge k into empty FIFO appears on data_out after edge k, empty=0 in same cycle.
- Read: after accepted shift_out at edge k, data_out shows next word (or 0 and empty=1) after edge k.
- Sustained simultaneous shift_in/shift_out at any 0<count≤DEPTH: one word per cycle throughput, order preserved.

## Test plan
- Reset then idle: data_out=0, empty=1, full=0, count=0, flags 0.
- Push 0x11,0x22,0x33,0x44 (DEPTH=4) on consecutive edges → data_out=0x11 after first edge, full=1 and count=4 after fourth; fifth push → overflow=1, contents unchanged.
- From full, four pops → data_out 0x22,0x33,0x44, then 0 with empty=1; extra pop → underflow=1, count stays 0.
- count=2 (0xA1,0xA2), shift_in+shift_out with 0xA3 → data_out=0xA2, count=2; next pop → 0xA3.
- Empty with simultaneous shift_in(0x5C)+shift_out → data_out=0x5C, count=1, underflow=1; full with simultaneous both → count=4, oldest removed, new word at tail.
- rst asserted with count=3 and shift_in high → all outputs return to reset values next cycle; subsequent push 0x77 → data_out=0x77, count=1.
